// File: rtl/butterfly_pipe.sv
// Radix-2 FFT butterfly, four register stages, per-sample DIT/DIF selection,
// optional divide-by-2 scaling, saturation with a sticky overflow flag.
module butterfly_pipe #(
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            ce,
  input  logic            in_valid,
  input  logic [2*DW-1:0] a_in,
  input  logic [2*DW-1:0] b_in,
  input  logic [2*TW-1:0] twiddle,
  input  logic            mode,
  input  logic            scale,
  input  logic            ovf_clr,
  output logic            out_valid,
  output logic [2*DW-1:0] a_out,
  output logic [2*DW-1:0] b_out,
  output logic            ovf
);

  localparam int PW = DW + TW;
  localparam logic signed [PW:0]   RND  = {{(PW-TW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [DW+1:0] ONE  = {{(DW+1){1'b0}}, 1'b1};

  // Sum or difference at DW+1 bits; optional round-half-up halving.
  function automatic logic signed [DW+1:0] add_scale(input logic signed [DW-1:0] x,
                                                     input logic signed [DW-1:0] y,
                                                     input logic sub, input logic scl);
    logic signed [DW+1:0] xe, ye, s;
    xe = {{2{x[DW-1]}}, x};
    ye = {{2{y[DW-1]}}, y};
    s  = sub ? (xe - ye) : (xe + ye);
    if (scl) s = (s + ONE) >>> 1;
    return s;
  endfunction

  // Combine two partial products, round to nearest and drop TW-1 fraction bits.
  function automatic logic signed [DW+1:0] mul_round(input logic signed [PW-1:0] p,
                                                     input logic signed [PW-1:0] q,
                                                     input logic sub);
    logic signed [PW:0] t;
    t = sub ? ({p[PW-1], p} - {q[PW-1], q}) : ({p[PW-1], p} + {q[PW-1], q});
    t = t + RND;
    return t[PW:TW-1];
  endfunction

  function automatic logic is_sat(input logic signed [DW+1:0] x);
    return (x > MAXV) || (x < MINV);
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+1:0] x);
    if (x > MAXV) return MAXV[DW-1:0];
    if (x < MINV) return MINV[DW-1:0];
    return x[DW-1:0];
  endfunction

  // ---- stage 1: input capture
  logic signed [DW-1:0] ar_p1, ai_p1, br_p1, bi_p1;
  logic signed [TW-1:0] wr_p1, wi_p1;
  logic                 mode_p1, scale_p1, vld_p1;

  // Valid for stage 1.
  always_ff @(posedge clk) begin
    if (clr)     vld_p1 <= 1'b0;
    else if (ce) vld_p1 <= in_valid;
  end

  // Data for stage 1.
  always_ff @(posedge clk) begin
    if (ce) begin
      ar_p1    <= a_in[2*DW-1:DW];
      ai_p1    <= a_in[DW-1:0];
      br_p1    <= b_in[2*DW-1:DW];
      bi_p1    <= b_in[DW-1:0];
      wr_p1    <= twiddle[2*TW-1:TW];
      wi_p1    <= twiddle[TW-1:0];
      mode_p1  <= mode;
      scale_p1 <= scale;
    end
  end

  // ---- stage 2: DIT partial products of b*W / DIF sum and difference
  logic signed [DW+1:0] sr_s2, si_s2, dr_s2, di_s2;
  logic                 sat_s2;
  assign sr_s2  = add_scale(ar_p1, br_p1, 1'b0, scale_p1);
  assign si_s2  = add_scale(ai_p1, bi_p1, 1'b0, scale_p1);
  assign dr_s2  = add_scale(ar_p1, br_p1, 1'b1, scale_p1);
  assign di_s2  = add_scale(ai_p1, bi_p1, 1'b1, scale_p1);
  assign sat_s2 = mode_p1 & (is_sat(sr_s2) | is_sat(si_s2) | is_sat(dr_s2) | is_sat(di_s2));

  logic signed [DW-1:0] xr_p2, xi_p2, dr_p2, di_p2;
  logic signed [PW-1:0] rr_p2, ii_p2, ri_p2, ir_p2;
  logic signed [TW-1:0] wr_p2, wi_p2;
  logic                 mode_p2, scale_p2, sat_p2, vld_p2;

  // Valid for stage 2.
  always_ff @(posedge clk) begin
    if (clr)     vld_p2 <= 1'b0;
    else if (ce) vld_p2 <= vld_p1;
  end

  // Data for stage 2; x carries a (DIT) or the saturated sum (DIF).
  always_ff @(posedge clk) begin
    if (ce) begin
      xr_p2    <= mode_p1 ? sat_dw(sr_s2) : ar_p1;
      xi_p2    <= mode_p1 ? sat_dw(si_s2) : ai_p1;
      dr_p2    <= sat_dw(dr_s2);
      di_p2    <= sat_dw(di_s2);
      rr_p2    <= br_p1 * wr_p1;
      ii_p2    <= bi_p1 * wi_p1;
      ri_p2    <= br_p1 * wi_p1;
      ir_p2    <= bi_p1 * wr_p1;
      wr_p2    <= wr_p1;
      wi_p2    <= wi_p1;
      mode_p2  <= mode_p1;
      scale_p2 <= scale_p1;
      sat_p2   <= sat_s2;
    end
  end

  // ---- stage 3: DIT rounds W*b / DIF forms partial products of (a-b)*W
  logic signed [DW+1:0] pr_s3, pi_s3;
  logic                 sat_s3;
  assign pr_s3  = mul_round(rr_p2, ii_p2, 1'b1);
  assign pi_s3  = mul_round(ri_p2, ir_p2, 1'b0);
  assign sat_s3 = sat_p2 | (~mode_p2 & (is_sat(pr_s3) | is_sat(pi_s3)));

  logic signed [DW-1:0] xr_p3, xi_p3, yr_p3, yi_p3;
  logic signed [PW-1:0] rr_p3, ii_p3, ri_p3, ir_p3;
  logic                 mode_p3, scale_p3, sat_p3, vld_p3;

  // Valid for stage 3.
  always_ff @(posedge clk) begin
    if (clr)     vld_p3 <= 1'b0;
    else if (ce) vld_p3 <= vld_p2;
  end

  // Data for stage 3.
  always_ff @(posedge clk) begin
    if (ce) begin
      xr_p3    <= xr_p2;
      xi_p3    <= xi_p2;
      yr_p3    <= sat_dw(pr_s3);
      yi_p3    <= sat_dw(pi_s3);
      rr_p3    <= dr_p2 * wr_p2;
      ii_p3    <= di_p2 * wi_p2;
      ri_p3    <= dr_p2 * wi_p2;
      ir_p3    <= di_p2 * wr_p2;
      mode_p3  <= mode_p2;
      scale_p3 <= scale_p2;
      sat_p3   <= sat_s3;
    end
  end

  // ---- stage 4: DIT add/sub with scaling / DIF product rounding, to outputs
  logic signed [DW+1:0] sr_s4, si_s4, dr_s4, di_s4, pr_s4, pi_s4;
  logic [2*DW-1:0]      a_s4, b_s4;
  logic                 sat_s4;

  // Select the final result for the sample's mode.
  always_comb begin
    sr_s4 = add_scale(xr_p3, yr_p3, 1'b0, scale_p3);
    si_s4 = add_scale(xi_p3, yi_p3, 1'b0, scale_p3);
    dr_s4 = add_scale(xr_p3, yr_p3, 1'b1, scale_p3);
    di_s4 = add_scale(xi_p3, yi_p3, 1'b1, scale_p3);
    pr_s4 = mul_round(rr_p3, ii_p3, 1'b1);
    pi_s4 = mul_round(ri_p3, ir_p3, 1'b0);
    a_s4  = {sat_dw(sr_s4), sat_dw(si_s4)};
    b_s4  = {sat_dw(dr_s4), sat_dw(di_s4)};
    sat_s4 = sat_p3 | is_sat(sr_s4) | is_sat(si_s4) | is_sat(dr_s4) | is_sat(di_s4);
    if (mode_p3) begin
      a_s4   = {xr_p3, xi_p3};
      b_s4   = {sat_dw(pr_s4), sat_dw(pi_s4)};
      sat_s4 = sat_p3 | is_sat(pr_s4) | is_sat(pi_s4);
    end
  end

  // Output registers and sticky overflow; a new saturation beats ovf_clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= vld_p3;
      if (vld_p3) begin
        a_out <= a_s4;
        b_out <= b_s4;
      end
      ovf <= (ovf & ~ovf_clr) | (vld_p3 & sat_s4);
    end
  end

endmodule
